// File: rtl/pll_gbe_lock_ctrl.sv
// Reset/lock supervisor for the GbE PLL: drives pll_rst, qualifies lock stability
// on refclk and gates downstream resets. Optional lock-loss counter: PLL_GBE_LOCK_CNT_EN.
module pll_gbe_lock_ctrl #(
   parameter int RST_CYCLES     = 16,
   parameter int STABLE_CYCLES  = 1024,
   parameter int TIMEOUT_CYCLES = 65536,
   parameter int CNT_W          = 8
) (
   input  logic             refclk,
   input  logic             rst,
   input  logic             pll_locked,
   input  logic             restart,
   output logic             pll_rst,
   output logic             clk_ok,
   output logic             domain_rst,
   output logic [1:0]       state
`ifdef PLL_GBE_LOCK_CNT_EN
   ,
   output logic [CNT_W-1:0] relock_cnt
`endif
);

   localparam int MAX_A = (RST_CYCLES > STABLE_CYCLES) ? RST_CYCLES : STABLE_CYCLES;
   localparam int MAX_P = (MAX_A > TIMEOUT_CYCLES) ? MAX_A : TIMEOUT_CYCLES;
   localparam int TW    = $clog2(MAX_P) + 1;

   localparam logic [TW-1:0] ONE        = TW'(1);
   localparam logic [TW-1:0] RST_LD     = TW'(RST_CYCLES);
   localparam logic [TW-1:0] STABLE_LD  = TW'(STABLE_CYCLES);
   localparam logic [TW-1:0] TIMEOUT_LD = TW'(TIMEOUT_CYCLES);

   typedef enum logic [1:0] {
      S_RESET  = 2'd0,
      S_WAIT   = 2'd1,
      S_STABLE = 2'd2,
      S_RUN    = 2'd3
   } state_e;

   state_e          state_q, state_d;
   logic [TW-1:0]   cnt_q, cnt_d;
   logic            sync1_q, lock_s_q;
   logic            pll_rst_q, pll_rst_d;
   logic            clk_ok_q, clk_ok_d;
   logic            domain_rst_q, domain_rst_d;

   // pll_locked is asynchronous; only lock_s_q is ever used for decisions
   always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
         sync1_q  <= 1'b0;
         lock_s_q <= 1'b0;
      end else begin
         sync1_q  <= pll_locked;
         lock_s_q <= sync1_q;
      end
   end

   // One shared down-counter, reloaded on every state entry and tested for 1
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q - ONE;
      case (state_q)
         S_RESET: begin
            if (cnt_q == ONE) begin
               state_d = S_WAIT;
               cnt_d   = TIMEOUT_LD;
            end
         end
         S_WAIT: begin
            if (restart) begin
               state_d = S_RESET;
               cnt_d   = RST_LD;
            end else if (lock_s_q) begin
               state_d = S_STABLE;
               cnt_d   = STABLE_LD;
            end else if (cnt_q == ONE) begin
               state_d = S_RESET;
               cnt_d   = RST_LD;
            end
         end
         S_STABLE: begin
            if (restart) begin
               state_d = S_RESET;
               cnt_d   = RST_LD;
            end else if (!lock_s_q) begin
               state_d = S_WAIT;
               cnt_d   = TIMEOUT_LD;
            end else if (cnt_q == ONE) begin
               state_d = S_RUN;
               cnt_d   = '0;
            end
         end
         S_RUN: begin
            cnt_d = cnt_q;
            if (!lock_s_q || restart) begin
               state_d = S_RESET;
               cnt_d   = RST_LD;
            end
         end
         default: begin
            state_d = S_RESET;
            cnt_d   = RST_LD;
         end
      endcase
      pll_rst_d    = (state_d == S_RESET);
      clk_ok_d     = (state_d == S_RUN);
      domain_rst_d = (state_d != S_RUN);
   end

   always_ff @(posedge refclk or posedge rst) begin
      if (rst) begin
         state_q      <= S_RESET;
         cnt_q        <= RST_LD;
         pll_rst_q    <= 1'b1;
         clk_ok_q     <= 1'b0;
         domain_rst_q <= 1'b1;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         pll_rst_q    <= pll_rst_d;
         clk_ok_q     <= clk_ok_d;
         domain_rst_q <= domain_rst_d;
      end
   end

   assign pll_rst    = pll_rst_q;
   assign clk_ok     = clk_ok_q;
   assign domain_rst = domain_rst_q;
   assign state      = state_q;

`ifdef PLL_GBE_LOCK_CNT_EN
   logic [CNT_W-1:0] relock_cnt_q, relock_cnt_d;

   // Lock loss in RUN wins over a simultaneous restart, so it is always counted
   always_comb begin
      relock_cnt_d = relock_cnt_q;
      if (state_q == S_RUN && !lock_s_q && !(&relock_cnt_q))
         relock_cnt_d = relock_cnt_q + CNT_W'(1);
   end

   always_ff @(posedge refclk or posedge rst) begin
      if (rst) relock_cnt_q <= '0;
      else     relock_cnt_q <= relock_cnt_d;
   end

   assign relock_cnt = relock_cnt_q;
`endif

endmodule

// File: tb/tb_pll_gbe_lock_ctrl.sv
// Randomised self-checking bench for pll_gbe_lock_ctrl against a cycle-level
// reference model (elapsed-time per state, lock history queue).
module tb_pll_gbe_lock_ctrl;

   localparam int RST_C = 4;
   localparam int STB_C = 8;
   localparam int TO_C  = 32;
   localparam int CW    = 8;

   logic refclk = 1'b0;
   logic rst = 1'b0;
   logic pll_locked = 1'b0;
   logic restart = 1'b0;
   logic pll_rst, clk_ok, domain_rst;
   logic [1:0] state;
`ifdef PLL_GBE_LOCK_CNT_EN
   logic [CW-1:0] relock_cnt;
`endif

   pll_gbe_lock_ctrl #(
      .RST_CYCLES(RST_C), .STABLE_CYCLES(STB_C), .TIMEOUT_CYCLES(TO_C), .CNT_W(CW)
   ) dut (
      .refclk(refclk), .rst(rst), .pll_locked(pll_locked), .restart(restart),
      .pll_rst(pll_rst), .clk_ok(clk_ok), .domain_rst(domain_rst), .state(state)
`ifdef PLL_GBE_LOCK_CNT_EN
      , .relock_cnt(relock_cnt)
`endif
   );

   always #5 refclk = ~refclk;

   int n_chk = 0;
   int n_err = 0;

   // Reference model: state code, cycles elapsed in it, loss count, lock history
   int m_st = 0;
   int m_age = 0;
   int m_cnt = 0;
   int lk_q[$];

   task automatic chk(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_st = 0; m_age = 0; m_cnt = 0;
      lk_q.delete();
   endtask

   task automatic model_step();
      int ls;
      ls = (lk_q.size() >= 2) ? lk_q[lk_q.size()-2] : 0;
      lk_q.push_back(int'(pll_locked));
      if (lk_q.size() > 4) void'(lk_q.pop_front());
      m_age++;
      case (m_st)
         0: if (m_age == RST_C) begin m_st = 1; m_age = 0; end
         1: begin
            if (restart)            begin m_st = 0; m_age = 0; end
            else if (ls == 1)       begin m_st = 2; m_age = 0; end
            else if (m_age == TO_C) begin m_st = 0; m_age = 0; end
         end
         2: begin
            if (restart)             begin m_st = 0; m_age = 0; end
            else if (ls == 0)        begin m_st = 1; m_age = 0; end
            else if (m_age == STB_C) begin m_st = 3; m_age = 0; end
         end
         default: begin
            if (ls == 0) begin
               m_st = 0; m_age = 0;
               if (m_cnt < (1 << CW) - 1) m_cnt++;
            end else if (restart) begin
               m_st = 0; m_age = 0;
            end
         end
      endcase
   endtask

   task automatic check_all();
      chk("state", int'(state), m_st);
      chk("pll_rst", int'(pll_rst), int'(m_st == 0));
      chk("clk_ok", int'(clk_ok), int'(m_st == 3));
      chk("domain_rst", int'(domain_rst), int'(m_st != 3));
`ifdef PLL_GBE_LOCK_CNT_EN
      chk("relock_cnt", int'(relock_cnt), m_cnt);
`endif
   endtask

   task automatic step();
      @(posedge refclk);
      model_step();
      @(negedge refclk);
      check_all();
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic wait_st(input int tgt, input int lim);
      for (int i = 0; i < lim && m_st != tgt; i++) step();
      chk("wait_state", int'(state), tgt);
   endtask

   // Async assert away from any clock edge; outputs must settle with no edge
   task automatic do_reset();
      @(negedge refclk);
      #2 rst = 1'b1;
      #1 model_reset();
      check_all();
      repeat (2) @(negedge refclk);
      check_all();
      rst = 1'b0;
   endtask

   initial begin
      do_reset();

      // Release with no lock: 4-cycle pll_rst, then repeated 32-cycle timeouts
      steps(3);
      chk("rst_pulse_hi", int'(pll_rst), 1);
      step();
      chk("rst_pulse_lo", int'(pll_rst), 0);
      steps(90);

      // Clean lock to RUN, then loss
      wait_st(1, 50);
      pll_locked = 1'b1;
      steps(3);
      chk("stable_after3", int'(state), 2);
      steps(STB_C);
      chk("clk_ok_rise", int'(clk_ok), 1);
      pll_locked = 1'b0;
      steps(3);
      chk("loss_pll_rst", int'(pll_rst), 1);
`ifdef PLL_GBE_LOCK_CNT_EN
      chk("first_loss", int'(relock_cnt), 1);
`endif

      // Unstable lock: 3-cycle dropout during STABLE
      pll_locked = 1'b1;
      wait_st(2, 60);
      steps(3);
      pll_locked = 1'b0;
      steps(3);
      pll_locked = 1'b1;
      steps(2);
      chk("unstable_back", int'(state), 1);
      steps(STB_C + 4);

      // restart in the same cycle lock_s falls in RUN
      wait_st(3, 60);
      pll_locked = 1'b0;
      steps(2);
      restart = 1'b1;
      step();
      restart = 1'b0;
      chk("simul_reset", int'(state), 0);
      steps(6);

      // Randomised lock and restart activity
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(11) == 0) pll_locked = ~pll_locked;
         restart = ($urandom_range(39) == 0);
         step();
      end
      restart = 1'b0;

      // Repeated lock losses: counter must saturate
      for (int k = 0; k < 260; k++) begin
         pll_locked = 1'b1;
         wait_st(3, 100);
         pll_locked = 1'b0;
         wait_st(0, 20);
      end
`ifdef PLL_GBE_LOCK_CNT_EN
      chk("relock_sat", int'(relock_cnt), (1 << CW) - 1);
`endif

      // Async reset in the middle of STABLE
      pll_locked = 1'b1;
      wait_st(2, 100);
      steps(2);
      do_reset();
      steps(RST_C + 6);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/pll_gbe_lock_ctrl.md
# pll_gbe_lock_ctrl

Reset and lock supervisor for the GbE clock PLL (25 MHz reference in; 125, 62.5 and 25 MHz out). It drives the PLL reset and resynchronises the PLL `locked` flag into the reference domain. Downstream MAC/PCS resets are released only after lock has been continuously stable for a programmable time. On any loss of lock or an explicit request, the PLL is put back through a reset/relock cycle. The block runs on the free-running reference clock, so it keeps operating while the PLL outputs are absent.

## Interface
- `RST_CYCLES`, 16: PLL reset pulse length in refclk cycles, ≥2.
- `STABLE_CYCLES`, 1024: cycles of continuous synchronised lock required before release, ≥2.
- `TIMEOUT_CYCLES`, 65536: maximum cycles in WAIT_LOCK before retrying the reset, > `RST_CYCLES`.
- `CNT_W`, 8: width of the lock-loss counter.
- Counter widths are derived with `$clog2` of the largest parameter + 1.

Ports:
- `refclk` in 1: free-running 25 MHz reference; the only clock.
- `rst` in 1: asynchronous, active-high reset for all flops.
- `pll_locked` in 1: PLL lock flag, asynchronous to `refclk`.
- `restart` in 1: synchronous single-cycle request to force a relock.
- `pll_rst` out 1: reset to the PLL, active-high.
- `clk_ok` out 1: PLL outputs are valid and stable.
- `domain_rst` out 1: downstream reset request, always `!clk_ok`.
- `state` out 2: current FSM state for status registers.
- `relock_cnt` out `CNT_W`: lock-loss event count (present only under the macro).

## Operation
- `pll_locked` passes through a 2-flop synchroniser; the result is `lock_s`. All decisions use `lock_s` only.
- FSM encoding: RESET=0, WAIT_LOCK=1, STABLE=2, RUN=3.
- **RESET**
  - `pll_rst`=1, `clk_ok`=0.
  - The counter runs for `RST_CYCLES` cycles, then the FSM moves to WAIT_LOCK.
  - `restart` is ignored in this state.
- **WAIT_LOCK**
  - `pll_rst`=0, `clk_ok`=0.
  - `lock_s`=1 moves to STABLE.
  - After `TIMEOUT_CYCLES` cycles without lock, the FSM moves to RESET.
  - `restart` moves to RESET.
- **STABLE**
  - `pll_rst`=0, `clk_ok`=0.
  - `lock_s`=0 returns to WAIT_LOCK; the stability counter clears and the timeout counter restarts from 0.
  - After `STABLE_CYCLES` consecutive cycles with `lock_s`=1, the FSM moves to RUN.
  - `restart` moves to RESET.
- **RUN**
  - `pll_rst`=0, `clk_ok`=1.
  - `lock_s`=0 moves to RESET (lock-loss event).
  - `restart` moves to RESET.
  - If both occur in the same cycle, lock loss takes priority and is counted once.
- A single shared down-counter is reloaded on every state entry.
- All outputs are registered.
- Reset values:
  - `pll_rst`=1, `clk_ok`=0, `domain_rst`=1.
  - `state`=0 (RESET), `relock_cnt`=0, synchroniser flops=0.
  - The RESET counter is loaded with `RST_CYCLES`.
- Asserting `rst` mid-operation returns the block to the reset values immediately, regardless of state. After deassertion a full RESET pulse is issued.

## Timing
- `pll_locked` → `lock_s`: 2 cycles.
- `lock_s` → `state` change: 1 cycle.
- `pll_rst` stays high for exactly `RST_CYCLES` cycles per RESET entry, including the entry after reset release.
- `clk_ok` rises `STABLE_CYCLES` cycles after entering STABLE. Minimum from a `pll_locked` rise to `clk_ok`: 2 + 1 + `STABLE_CYCLES` cycles.
- On `pll_locked` falling in RUN:
  - `clk_ok` falls and `pll_rst` rises 3 cycles later (2 synchroniser + 1 register).
  - A lock glitch shorter than 1 refclk period can be missed; this is accepted.
- `restart` in RUN: `clk_ok`=0 and `pll_rst`=1 on the next cycle.
- A WAIT_LOCK timeout occurs exactly `TIMEOUT_CYCLES` cycles after WAIT_LOCK entry.

## Configuration
- `PLL_GBE_LOCK_CNT_EN` defined:
  - `relock_cnt` increments by 1 on every RUN→RESET transition caused by lock loss.
  - It does not count `restart` or timeouts.
  - It saturates at 2^`CNT_W`−1 and is cleared only by `rst`.
- Macro undefined: the `relock_cnt` port and counter logic are not present. All other behaviour is identical.

## Test plan
All scenarios use `RST_CYCLES`=4, `STABLE_CYCLES`=8, `TIMEOUT_CYCLES`=32.

- **Reset and release:** release `rst` with `pll_locked`=0 → `pll_rst`=1 for 4 cycles, then 0; `state`=1; `clk_ok`=0.
- **Clean lock:** drive `pll_locked`=1 in WAIT_LOCK → `state`=2 after 3 cycles; `clk_ok`=1 and `domain_rst`=0 exactly 8 cycles later.
- **Unstable lock:** a `pll_locked` low pulse of 3 cycles during STABLE → `state` returns to 1 and `clk_ok` stays 0. The FSM reaches RUN only after 8 uninterrupted lock cycles.
- **Timeout:** hold `pll_locked`=0 → after 32 cycles in WAIT_LOCK, `pll_rst` pulses high for 4 cycles. This repeats indefinitely; `relock_cnt` stays 0.
- **Lock loss and counting:**
  - In RUN, drop `pll_locked` → `clk_ok`=0 and `pll_rst`=1 3 cycles later.
  - With the macro defined, `relock_cnt`=1.
  - After 255 further losses at `CNT_W`=8, `relock_cnt` holds 255.
- **Simultaneous and async events:**
  - `restart`=1 in the same cycle that `lock_s` falls in RUN → one RESET entry, `relock_cnt` +1.
  - `rst` asserted mid-STABLE → all outputs reach reset values without any clock edge.
